pipe_hazard_tracker: RTL and testbench

//  Datapath-side partner of the pipeline controller. Consumes per-stage rst/en and returns per-stage valid flags.

---
 rtl/pipe_hazard_tracker_pkg.sv | 20 ++
 rtl/pipe_stage_slice.sv | 44 ++++
 rtl/pipe_hazard_tracker.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared constants and helpers for the pipeline hazard tracker.
// Default widths plus the write-enable gating rule used by every stage.
package pipe_hazard_tracker_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int PERF_W_DEF = 32;

  // wen, is_load, is_store flags ride with the rd/rt addresses
  localparam int TAG_FLAGS = 3;

  // A write to r0 is never a real hazard, so it is masked here
  function automatic logic wen_gate(
    input logic wen,
    input logic vld,
    input logic nz
  );
    return wen & vld & nz;
  endfunction

endpackage

// File: rtl/pipe_stage_slice.sv
// One pipeline register: valid bit plus packed tag bundle.
// Ports: clk, rst_i (global), srst_i (stage flush), en_i, valid_i/tag_i in, valid_o/tag_o out.
module pipe_stage_slice #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         srst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] tag_i,
  output logic         valid_o,
  output logic [W-1:0] tag_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (srst_i) begin
      valid_d = 1'b0;
      tag_d   = '0;
    end else if (en_i) begin
      valid_d = valid_i;
      tag_d   = tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Tracks per-stage valid flags and hazard tags (rd, wen, load/store, rt) through EXE/MEM/WB.
// Ports: per-stage rst/en in, ID decode tags in, stage valids + gated hazard tags + inst_retire out.
// Optional PIPE_PERF_EN adds saturating cycle_cnt, retire_cnt and bubble_cnt outputs.
module pipe_hazard_tracker
  import pipe_hazard_tracker_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
`ifdef PIPE_PERF_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_rst,
  input  logic              if_en,
  input  logic              id_rst,
  input  logic              id_en,
  input  logic              exe_rst,
  input  logic              exe_en,
  input  logic              mem_rst,
  input  logic              mem_en,
  input  logic              wb_rst,
  input  logic              wb_en,
  input  logic              id_wb_wen,
  input  logic [ADDR_W-1:0] id_regw_addr,
  input  logic              id_is_load,
  input  logic              id_is_store,
  input  logic [ADDR_W-1:0] id_addr_rt,
  output logic              if_valid,
  output logic              id_valid,
  output logic              exe_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              is_load_exe,
  output logic              is_store_exe,
  output logic [ADDR_W-1:0] regw_addr_exe,
  output logic              wb_wen_exe,
  output logic              is_load_mem,
  output logic              is_store_mem,
  output logic [ADDR_W-1:0] addr_rt_mem,
  output logic [ADDR_W-1:0] regw_addr_mem,
  output logic              wb_wen_mem,
  output logic [ADDR_W-1:0] regw_addr_wb,
  output logic              wb_wen_wb,
  output logic              inst_retire
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retire_cnt,
  output logic [PERF_W-1:0] bubble_cnt
`endif
);

  // Tag layout: {wen, load, store, rt, rd}
  localparam int TW    = 2 * ADDR_W + TAG_FLAGS;
  localparam int I_ST  = 2 * ADDR_W;
  localparam int I_LD  = 2 * ADDR_W + 1;
  localparam int I_WEN = 2 * ADDR_W + 2;

  logic if_valid_q, if_valid_d;
  logic id_valid_q, id_valid_d;

  always_comb begin
    if_valid_d = if_valid_q;
    if (if_rst)     if_valid_d = 1'b0;
    else if (if_en) if_valid_d = 1'b1;
  end

  always_comb begin
    id_valid_d = id_valid_q;
    if (id_rst)     id_valid_d = 1'b0;
    else if (id_en) id_valid_d = if_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      id_valid_q <= 1'b0;
    end else begin
      if_valid_q <= if_valid_d;
      id_valid_q <= id_valid_d;
    end
  end

  logic [TW-1:0]     exe_tag_in, exe_tag, mem_tag;
  logic [ADDR_W:0]   wb_tag_in, wb_tag;
  logic              exe_v, mem_v, wb_v;

  assign exe_tag_in = {id_wb_wen, id_is_load, id_is_store,
                       id_addr_rt, id_regw_addr};

  pipe_stage_slice #(.W(TW)) u_exe (
    .clk     (clk),
    .rst_i   (rst),
    .srst_i  (exe_rst),
    .en_i    (exe_en),
    .valid_i (id_valid_q),
    .tag_i   (exe_tag_in),
    .valid_o (exe_v),
    .tag_o   (exe_tag)
  );

  pipe_stage_slice #(.W(TW)) u_mem (
    .clk     (clk),
    .rst_i   (rst),
    .srst_i  (mem_rst),
    .en_i    (mem_en),
    .valid_i (exe_v),
    .tag_i   (exe_tag),
    .valid_o (mem_v),
    .tag_o   (mem_tag)
  );

  // WB only needs the write-back part of the bundle
  assign wb_tag_in = {mem_tag[I_WEN], mem_tag[ADDR_W-1:0]};

  pipe_stage_slice #(.W(ADDR_W + 1)) u_wb (
    .clk     (clk),
    .rst_i   (rst),
    .srst_i  (wb_rst),
    .en_i    (wb_en),
    .valid_i (mem_v),
    .tag_i   (wb_tag_in),
    .valid_o (wb_v),
    .tag_o   (wb_tag)
  );

  assign if_valid  = if_valid_q;
  assign id_valid  = id_valid_q;
  assign exe_valid = exe_v;
  assign mem_valid = mem_v;
  assign wb_valid  = wb_v;

  assign is_load_exe   = exe_tag[I_LD] & exe_v;
  assign is_store_exe  = exe_tag[I_ST] & exe_v;
  assign regw_addr_exe = exe_tag[ADDR_W-1:0];
  assign wb_wen_exe    = wen_gate(exe_tag[I_WEN], exe_v,
                                  |exe_tag[ADDR_W-1:0]);

  assign is_load_mem   = mem_tag[I_LD] & mem_v;
  assign is_store_mem  = mem_tag[I_ST] & mem_v;
  assign addr_rt_mem   = mem_tag[2*ADDR_W-1:ADDR_W];
  assign regw_addr_mem = mem_tag[ADDR_W-1:0];
  assign wb_wen_mem    = wen_gate(mem_tag[I_WEN], mem_v,
                                  |mem_tag[ADDR_W-1:0]);

  assign regw_addr_wb  = wb_tag[ADDR_W-1:0];
  assign wb_wen_wb     = wen_gate(wb_tag[ADDR_W], wb_v,
                                  |wb_tag[ADDR_W-1:0]);

  assign inst_retire = wb_v & wb_en & ~wb_rst & ~rst;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] cyc_q, cyc_d;
  logic [PERF_W-1:0] ret_q, ret_d;
  logic [PERF_W-1:0] bub_q, bub_d;
  logic              bubble;

  // A flush always loads a bubble; an enable loads one if ID is empty
  assign bubble = (exe_en | exe_rst) & (exe_rst | ~id_valid_q);

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    bub_d = bub_q;
    if (~&cyc_q)                cyc_d = cyc_q + PERF_W'(1);
    if (inst_retire && ~&ret_q) ret_d = ret_q + PERF_W'(1);
    if (bubble && ~&bub_q)      bub_d = bub_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
      bub_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
      bub_q <= bub_d;
    end
  end

  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
  assign bubble_cnt = bub_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Scoreboard bench for pipe_hazard_tracker: directed scenarios then random traffic.
// Expected outputs come from a slot-array pipeline model and are checked by a monitor.
module tb_pipe_hazard_tracker;

  localparam int AW = 5;
`ifdef PIPE_PERF_EN
  localparam int PW = 4;
  localparam int SAT = 15;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic if_rst, if_en, id_rst, id_en, exe_rst, exe_en;
  logic mem_rst, mem_en, wb_rst, wb_en;
  logic id_wb_wen, id_is_load, id_is_store;
  logic [AW-1:0] id_regw_addr, id_addr_rt;
  logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic is_load_exe, is_store_exe, wb_wen_exe;
  logic is_load_mem, is_store_mem, wb_wen_mem, wb_wen_wb;
  logic [AW-1:0] regw_addr_exe, addr_rt_mem, regw_addr_mem, regw_addr_wb;
  logic inst_retire;
`ifdef PIPE_PERF_EN
  logic [PW-1:0] cycle_cnt, retire_cnt, bubble_cnt;
`endif

  pipe_hazard_tracker #(
    .ADDR_W (AW)
`ifdef PIPE_PERF_EN
    , .PERF_W (PW)
`endif
  ) dut (
    .clk (clk), .rst (rst),
    .if_rst (if_rst), .if_en (if_en),
    .id_rst (id_rst), .id_en (id_en),
    .exe_rst (exe_rst), .exe_en (exe_en),
    .mem_rst (mem_rst), .mem_en (mem_en),
    .wb_rst (wb_rst), .wb_en (wb_en),
    .id_wb_wen (id_wb_wen), .id_regw_addr (id_regw_addr),
    .id_is_load (id_is_load), .id_is_store (id_is_store),
    .id_addr_rt (id_addr_rt),
    .if_valid (if_valid), .id_valid (id_valid),
    .exe_valid (exe_valid), .mem_valid (mem_valid),
    .wb_valid (wb_valid),
    .is_load_exe (is_load_exe), .is_store_exe (is_store_exe),
    .regw_addr_exe (regw_addr_exe), .wb_wen_exe (wb_wen_exe),
    .is_load_mem (is_load_mem), .is_store_mem (is_store_mem),
    .addr_rt_mem (addr_rt_mem), .regw_addr_mem (regw_addr_mem),
    .wb_wen_mem (wb_wen_mem),
    .regw_addr_wb (regw_addr_wb), .wb_wen_wb (wb_wen_wb),
    .inst_retire (inst_retire)
`ifdef PIPE_PERF_EN
    , .cycle_cnt (cycle_cnt), .retire_cnt (retire_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct {
    bit       v;
    bit       we;
    bit       ld;
    bit       st;
    bit [4:0] rd;
    bit [4:0] rt;
  } slot_t;

  typedef struct packed {
    logic [4:0]  vld;
    logic [7:0]  exe;
    logic [12:0] mem;
    logic [5:0]  wb;
    logic        ret;
    logic [11:0] perf;
  } obs_t;

  slot_t m[5];
  slot_t empty_slot;
  int cc, rc, bc;
  obs_t sb[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
  endtask

  function automatic logic wgate(input slot_t s);
    return s.we && s.v && (s.rd != 0);
  endfunction

  function automatic obs_t predict(input bit r, input bit [4:0] sr,
                                   input bit [4:0] en);
    obs_t o;
    for (int i = 0; i < 5; i++) o.vld[i] = m[i].v;
    o.exe = {m[2].ld & m[2].v, m[2].st & m[2].v, wgate(m[2]), m[2].rd};
    o.mem = {m[3].ld & m[3].v, m[3].st & m[3].v, wgate(m[3]),
             m[3].rt, m[3].rd};
    o.wb  = {wgate(m[4]), m[4].rd};
    o.ret = m[4].v && en[4] && !sr[4] && !r;
    o.perf = '0;
`ifdef PIPE_PERF_EN
    o.perf = {cc[3:0], rc[3:0], bc[3:0]};
`endif
    return o;
  endfunction

  // One cycle: apply inputs, queue expected view, advance the model
  task automatic cyc(input bit r, input bit [4:0] sr, input bit [4:0] en,
                     input bit we, input bit [4:0] rd, input bit ld,
                     input bit sto, input bit [4:0] rt);
    slot_t nx[5];
    obs_t  e;
    rst = r;
    {wb_rst, mem_rst, exe_rst, id_rst, if_rst} = sr;
    {wb_en, mem_en, exe_en, id_en, if_en} = en;
    id_wb_wen = we; id_regw_addr = rd; id_is_load = ld;
    id_is_store = sto; id_addr_rt = rt;
    e = predict(r, sr, en);
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      nx[i] = m[i];
      if (r || sr[i]) nx[i] = empty_slot;
      else if (en[i]) begin
        nx[i] = empty_slot;
        case (i)
          0: nx[i].v = 1;
          1: nx[i].v = m[0].v;
          2: nx[i] = '{m[1].v, we, ld, sto, rd, rt};
          default: nx[i] = m[i-1];
        endcase
      end
    end
    if (r) begin
      cc = 0; rc = 0; bc = 0;
    end else begin
`ifdef PIPE_PERF_EN
      if (cc < SAT) cc++;
      if (e.ret && rc < SAT) rc++;
      if ((en[2] || sr[2]) && (sr[2] || !m[1].v) && bc < SAT) bc++;
`endif
    end
    m = nx;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t e, a;
      e = sb.pop_front();
      a.vld = {wb_valid, mem_valid, exe_valid, id_valid, if_valid};
      a.exe = {is_load_exe, is_store_exe, wb_wen_exe, regw_addr_exe};
      a.mem = {is_load_mem, is_store_mem, wb_wen_mem,
               addr_rt_mem, regw_addr_mem};
      a.wb  = {wb_wen_wb, regw_addr_wb};
      a.ret = inst_retire;
      a.perf = '0;
      chk("valid", 32'(a.vld), 32'(e.vld));
      chk("exe_tags", 32'(a.exe), 32'(e.exe));
      chk("mem_tags", 32'(a.mem), 32'(e.mem));
      chk("wb_tags", 32'(a.wb), 32'(e.wb));
      chk("retire", 32'(a.ret), 32'(e.ret));
`ifdef PIPE_PERF_EN
      a.perf = {cycle_cnt, retire_cnt, bubble_cnt};
      chk("perf", 32'(a.perf), 32'(e.perf));
`endif
    end
  end

  localparam bit [4:0] ALL = 5'b11111;

  initial begin
    empty_slot = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) m[i] = empty_slot;
    cc = 0; rc = 0; bc = 0;
    rst = 1;
    {wb_rst, mem_rst, exe_rst, id_rst, if_rst} = '0;
    {wb_en, mem_en, exe_en, id_en, if_en} = ALL;
    id_wb_wen = 0; id_regw_addr = 0; id_is_load = 0;
    id_is_store = 0; id_addr_rt = 0;
    @(posedge clk);
    #1;
    // reset held a second cycle, then release with everything enabled
    cyc(1, 0, ALL, 1, 5'd9, 1, 1, 5'd3);
    cyc(0, 0, ALL, 0, 0, 0, 0, 0);
    cyc(0, 0, ALL, 0, 0, 0, 0, 0);
    // load to r5 travelling to retire
    cyc(0, 0, ALL, 1, 5'd5, 1, 0, 5'd2);
    repeat (5) cyc(0, 0, ALL, 0, 0, 0, 0, 0);
    // stall bubble with r7 waiting in ID
    cyc(0, 0, ALL, 0, 5'd1, 0, 0, 0);
    cyc(0, 5'b00100, 5'b11100, 1, 5'd7, 0, 1, 5'd7);
    cyc(0, 0, ALL, 1, 5'd7, 0, 1, 5'd7);
    repeat (4) cyc(0, 0, ALL, 0, 0, 0, 0, 0);
    // write to r0 never asserts a write enable
    cyc(0, 0, ALL, 1, 5'd0, 1, 0, 5'd4);
    repeat (4) cyc(0, 0, ALL, 0, 0, 0, 0, 0);
    // flush beats enable, then MEM held three cycles
    cyc(0, 0, ALL, 1, 5'd12, 0, 1, 5'd13);
    cyc(0, 5'b00100, ALL, 1, 5'd14, 1, 0, 5'd15);
    cyc(0, 0, ALL, 1, 5'd16, 0, 1, 5'd17);
    cyc(0, 0, ALL, 1, 5'd18, 1, 0, 5'd19);
    repeat (3) cyc(0, 0, 5'b10111, 1, 5'd20, 0, 0, 5'd21);
    repeat (3) cyc(0, 0, ALL, 0, 0, 0, 0, 0);
    // reset mid-flight
    cyc(1, 0, ALL, 1, 5'd22, 1, 1, 5'd23);
    repeat (3) cyc(0, 0, ALL, 1, 5'd24, 0, 0, 5'd25);
    for (int n = 0; n < 400; n++) begin
      bit r;
      bit [4:0] sr, en, rd;
      r = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 5; k++) begin
        sr[k] = ($urandom_range(0, 11) == 0);
        en[k] = ($urandom_range(0, 4) != 0);
      end
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      cyc(r, sr, en, 1'($urandom), rd, 1'($urandom), 1'($urandom),
          5'($urandom));
    end
    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tot++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
